// File: rtl/branch_target_predictor_if.sv
// rtl/branch_target_predictor_if.sv - fetch lookup and resolve/train bundle for the branch target predictor
interface branch_target_predictor_if #(
    parameter int HIST_W = 4
);
    logic [31:0]       lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [31:0]       pred_npc;
    logic [HIST_W-1:0] pred_hist;
    logic              upd_en;
    logic [31:0]       upd_pc;
    logic [HIST_W-1:0] upd_hist;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_mispredict;
    logic [31:0]       mispredict_cnt;

    modport master (
        output lookup_pc, upd_en, upd_pc, upd_hist, upd_taken, upd_target, upd_mispredict,
        input  pred_hit, pred_taken, pred_npc, pred_hist, mispredict_cnt
    );

    modport slave (
        input  lookup_pc, upd_en, upd_pc, upd_hist, upd_taken, upd_target, upd_mispredict,
        output pred_hit, pred_taken, pred_npc, pred_hist, mispredict_cnt
    );
endinterface

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with saturating direction counters, bimodal or gshare index
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int MODE    = 0,
    parameter int HIST_W  = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    branch_target_predictor_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [CTR_W-1:0]   r_ctr    [ENTRIES];
    logic [HIST_W-1:0]  r_ghr;
    logic [31:0]        r_mispredict_cnt;

    logic [IDX_W-1:0]   w_lk_hist_ext;
    logic [IDX_W-1:0]   w_up_hist_ext;
    logic [IDX_W-1:0]   w_lk_idx;
    logic [IDX_W-1:0]   w_up_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic [TAG_W-1:0]   w_up_tag;
    logic               w_lk_hit;
    logic               w_lk_taken;
    logic               w_up_hit;
    logic [HIST_W-1:0]  w_ghr_next;
    logic               w_unused_bits;

    // Gshare folds history into the low index bits; bimodal leaves the index as pure PC bits.
    always_comb begin
        w_lk_hist_ext = '0;
        w_up_hist_ext = '0;
        if (MODE == 1) begin
            w_lk_hist_ext[HIST_W-1:0] = r_ghr;
            w_up_hist_ext[HIST_W-1:0] = bp.upd_hist;
        end
    end

    assign w_lk_idx = bp.lookup_pc[IDX_W+1:2] ^ w_lk_hist_ext;
    assign w_up_idx = bp.upd_pc[IDX_W+1:2] ^ w_up_hist_ext;
    assign w_lk_tag = bp.lookup_pc[31:IDX_W+2];
    assign w_up_tag = bp.upd_pc[31:IDX_W+2];

    assign w_lk_hit   = ~i_rst & r_valid[w_lk_idx] & (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit & r_ctr[w_lk_idx][CTR_W-1];
    assign w_up_hit   = r_valid[w_up_idx] & (r_tag[w_up_idx] == w_up_tag);

    assign bp.pred_hit       = w_lk_hit;
    assign bp.pred_taken     = w_lk_taken;
    assign bp.pred_npc       = w_lk_taken ? r_target[w_lk_idx] : bp.lookup_pc + 32'd4;
    assign bp.pred_hist      = r_ghr;
    assign bp.mispredict_cnt = r_mispredict_cnt;

    assign w_unused_bits = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0], bp.upd_hist};

    generate
        if (HIST_W == 1) begin : g_hist_one
            assign w_ghr_next = bp.upd_taken;
        end else begin : g_hist_multi
            assign w_ghr_next = {r_ghr[HIST_W-2:0], bp.upd_taken};
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ghr <= '0;
        end else if (MODE == 1 && bp.upd_en) begin
            r_ghr <= w_ghr_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mispredict_cnt <= '0;
        end else if (bp.upd_en && bp.upd_mispredict && r_mispredict_cnt != 32'hFFFF_FFFF) begin
            r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
        end
    end

    // A not-taken miss leaves the table alone so cold fall-through branches never evict useful entries.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_WNT;
            end
        end else if (bp.upd_en) begin
            if (w_up_hit) begin
                if (bp.upd_taken) begin
                    r_target[w_up_idx] <= bp.upd_target;
                    if (r_ctr[w_up_idx] != CTR_MAX) begin
                        r_ctr[w_up_idx] <= r_ctr[w_up_idx] + CTR_W'(1);
                    end
                end else if (r_ctr[w_up_idx] != '0) begin
                    r_ctr[w_up_idx] <= r_ctr[w_up_idx] - CTR_W'(1);
                end
            end else if (bp.upd_taken) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= bp.upd_target;
                r_ctr[w_up_idx]    <= CTR_WT;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed vector bench for bimodal and gshare predictor instances
module tb_branch_target_predictor;
    logic clk;
    logic rst;

    branch_target_predictor_if #(.HIST_W(4)) if0 ();
    branch_target_predictor_if #(.HIST_W(4)) if1 ();

    branch_target_predictor #(.ENTRIES(16), .CTR_W(2), .MODE(0), .HIST_W(4)) u_dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bp    (if0.slave)
    );

    branch_target_predictor #(.ENTRIES(16), .CTR_W(2), .MODE(1), .HIST_W(4)) u_dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bp    (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lk;
        logic        en;
        logic [31:0] upc;
        logic        tk;
        logic [31:0] tgt;
        logic        mis;
        logic        hit;
        logic        ptk;
        logic [31:0] npc;
    } vec_t;

    vec_t vt[28];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic [31:0] lk, input logic en, input logic [31:0] upc,
                                input logic tk, input logic [31:0] tgt, input logic mis,
                                input logic hit, input logic ptk, input logic [31:0] npc);
        vec_t v;
        v.lk = lk; v.en = en; v.upc = upc; v.tk = tk; v.tgt = tgt; v.mis = mis;
        v.hit = hit; v.ptk = ptk; v.npc = npc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle0();
        if0.upd_en = 1'b0; if0.upd_pc = '0; if0.upd_hist = '0;
        if0.upd_taken = 1'b0; if0.upd_target = '0; if0.upd_mispredict = 1'b0;
    endtask

    task automatic upd1(input logic [31:0] pc, input logic [3:0] hist, input logic tk, input logic [31:0] tgt);
        @(negedge clk);
        if1.upd_en = 1'b1; if1.upd_pc = pc; if1.upd_hist = hist;
        if1.upd_taken = tk; if1.upd_target = tgt; if1.upd_mispredict = 1'b0;
        @(negedge clk);
        if1.upd_en = 1'b0;
    endtask

    task automatic look1(input string nm, input logic [31:0] pc, input logic hit, input logic [31:0] npc);
        if1.lookup_pc = pc;
        #1;
        chk({nm, " hit"}, {31'd0, if1.pred_hit}, {31'd0, hit});
        chk({nm, " npc"}, if1.pred_npc, npc);
    endtask

    initial begin
        // Bimodal sequence; each lookup is observed before the edge that commits the same row's update.
        vt[0]  = mk(32'h40,   0, 32'h0,    0, 32'h0,    0, 0, 0, 32'h44);
        vt[1]  = mk(32'h40,   1, 32'h40,   1, 32'h100,  1, 0, 0, 32'h44);
        vt[2]  = mk(32'h40,   0, 32'h0,    0, 32'h0,    0, 1, 1, 32'h100);
        vt[3]  = mk(32'h80,   0, 32'h0,    0, 32'h0,    0, 0, 0, 32'h84);
        vt[4]  = mk(32'h40,   1, 32'h40,   1, 32'h100,  0, 1, 1, 32'h100);
        vt[5]  = mk(32'h40,   1, 32'h40,   1, 32'h100,  0, 1, 1, 32'h100);
        vt[6]  = mk(32'h40,   1, 32'h40,   1, 32'h100,  0, 1, 1, 32'h100);
        vt[7]  = mk(32'h40,   1, 32'h40,   0, 32'h0,    0, 1, 1, 32'h100);
        vt[8]  = mk(32'h40,   0, 32'h0,    0, 32'h0,    0, 1, 1, 32'h100);
        vt[9]  = mk(32'h40,   1, 32'h40,   0, 32'h0,    1, 1, 1, 32'h100);
        vt[10] = mk(32'h40,   0, 32'h0,    0, 32'h0,    0, 1, 0, 32'h44);
        vt[11] = mk(32'h40,   1, 32'h40,   0, 32'h0,    0, 1, 0, 32'h44);
        vt[12] = mk(32'h40,   1, 32'h40,   0, 32'h0,    0, 1, 0, 32'h44);
        vt[13] = mk(32'h40,   1, 32'h40,   1, 32'h200,  0, 1, 0, 32'h44);
        vt[14] = mk(32'h40,   0, 32'h0,    0, 32'h0,    0, 1, 0, 32'h44);
        vt[15] = mk(32'h40,   1, 32'h40,   1, 32'h200,  0, 1, 0, 32'h44);
        vt[16] = mk(32'h40,   0, 32'h0,    0, 32'h0,    0, 1, 1, 32'h200);
        vt[17] = mk(32'h40,   1, 32'h80,   0, 32'h0,    0, 1, 1, 32'h200);
        vt[18] = mk(32'h80,   0, 32'h0,    0, 32'h0,    0, 0, 0, 32'h84);
        vt[19] = mk(32'h40,   0, 32'h0,    0, 32'h0,    0, 1, 1, 32'h200);
        vt[20] = mk(32'h80,   1, 32'h80,   1, 32'h300,  0, 0, 0, 32'h84);
        vt[21] = mk(32'h80,   0, 32'h0,    0, 32'h0,    0, 1, 1, 32'h300);
        vt[22] = mk(32'h40,   0, 32'h0,    0, 32'h0,    0, 0, 0, 32'h44);
        vt[23] = mk(32'h40,   0, 32'h40,   1, 32'h500,  1, 0, 0, 32'h44);
        vt[24] = mk(32'h40,   0, 32'h0,    0, 32'h0,    0, 0, 0, 32'h44);
        vt[25] = mk(32'h1004, 1, 32'h1004, 1, 32'h2000, 0, 0, 0, 32'h1008);
        vt[26] = mk(32'h1004, 0, 32'h0,    0, 32'h0,    0, 1, 1, 32'h2000);
        vt[27] = mk(32'h84,   0, 32'h0,    0, 32'h0,    0, 0, 0, 32'h88);

        rst = 1'b1;
        if0.lookup_pc = 32'h40;
        idle0();
        if1.lookup_pc = 32'h40;
        if1.upd_en = 1'b0; if1.upd_pc = '0; if1.upd_hist = '0;
        if1.upd_taken = 1'b0; if1.upd_target = '0; if1.upd_mispredict = 1'b0;
        #1;
        chk("reset hit",  {31'd0, if0.pred_hit}, 32'd0);
        chk("reset npc",  if0.pred_npc, 32'h44);
        chk("reset cnt",  if0.mispredict_cnt, 32'd0);
        chk("reset hist", {28'd0, if1.pred_hist}, 32'd0);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if0.lookup_pc      = vt[i].lk;
            if0.upd_en         = vt[i].en;
            if0.upd_pc         = vt[i].upc;
            if0.upd_hist       = 4'h0;
            if0.upd_taken      = vt[i].tk;
            if0.upd_target     = vt[i].tgt;
            if0.upd_mispredict = vt[i].mis;
            #1;
            chk($sformatf("v%0d hit", i),   {31'd0, if0.pred_hit},   {31'd0, vt[i].hit});
            chk($sformatf("v%0d taken", i), {31'd0, if0.pred_taken}, {31'd0, vt[i].ptk});
            chk($sformatf("v%0d npc", i),   if0.pred_npc,            vt[i].npc);
        end
        @(negedge clk);
        idle0();
        #1;
        chk("bimodal cnt", if0.mispredict_cnt, 32'd2);
        chk("bimodal hist", {28'd0, if0.pred_hist}, 32'd0);

        // Gshare: outcomes T,T,N,T build GHR 1101; entry lands at pc[5:2]^hist.
        upd1(32'h40, 4'h0, 1'b1, 32'h100);
        upd1(32'h40, 4'h1, 1'b1, 32'h180);
        upd1(32'h44, 4'h3, 1'b0, 32'h0);
        upd1(32'h48, 4'h6, 1'b1, 32'h400);
        #1;
        chk("gshare ghr", {28'd0, if1.pred_hist}, 32'hD);
        look1("gs 0x48", 32'h48, 1'b0, 32'h4C);
        look1("gs 0x64", 32'h64, 1'b1, 32'h400);
        upd1(32'h64, 4'hD, 1'b1, 32'h500);
        #1;
        chk("gshare ghr2", {28'd0, if1.pred_hist}, 32'hB);
        look1("gs 0x64 b", 32'h64, 1'b0, 32'h68);
        look1("gs 0x7c", 32'h7C, 1'b1, 32'h500);

        // Reset asserted mid-stream with an allocating update pending.
        @(negedge clk);
        if0.lookup_pc = 32'h1004;
        #1;
        chk("pre-rst hit", {31'd0, if0.pred_hit}, 32'd1);
        if0.upd_en = 1'b1; if0.upd_pc = 32'h2008; if0.upd_taken = 1'b1;
        if0.upd_target = 32'h3000; if0.upd_mispredict = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst hit",  {31'd0, if0.pred_hit},   32'd0);
        chk("rst tk",   {31'd0, if0.pred_taken}, 32'd0);
        chk("rst npc",  if0.pred_npc,            32'h1008);
        chk("rst cnt",  if0.mispredict_cnt,      32'd0);
        chk("rst hist", {28'd0, if1.pred_hist},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle0();
        if0.lookup_pc = 32'h2008;
        #1;
        chk("post-rst 0x2008 hit", {31'd0, if0.pred_hit}, 32'd0);
        if0.lookup_pc = 32'h1004;
        #1;
        chk("post-rst 0x1004 hit", {31'd0, if0.pred_hit}, 32'd0);

        // Counter saturation from just below the ceiling.
        @(negedge clk);
        force u_dut0.r_mispredict_cnt = 32'hFFFF_FFFE;
        #1;
        release u_dut0.r_mispredict_cnt;
        if0.upd_en = 1'b1; if0.upd_pc = 32'h40; if0.upd_taken = 1'b0; if0.upd_mispredict = 1'b1;
        @(negedge clk);
        #1;
        chk("cnt sat 1", if0.mispredict_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        chk("cnt sat 2", if0.mispredict_cnt, 32'hFFFF_FFFF);
        idle0();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
